rotate_engine: RTL and testbench

- Frame-buffered pixel rotator for the image pipeline. It generalises the fixed 512x512 write-then-read-rotated adapter.
- Parameters cover image width, height and pixel width, and the block supports four rotation modes selected per frame.
- A full frame is accepted in raster order through a valid/ready stream into internal single-port RAM. The frame is then streamed out in rotated raster order with start-of-line and end-of-frame markers.

---
 rtl/rotate_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_rotate_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_engine.sv
// rtl/rotate_engine.sv - frame-buffered pixel rotator (0/90/180/270 degrees)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, rot[1:0]        frame start pulse (IDLE only) and rotation mode
//   s_valid/s_ready/s_data source pixel stream, raster order
//   m_valid/m_ready/m_data rotated pixel stream, rotated raster order
//   m_sol, m_eof           first pixel of output row / last pixel of frame
//   busy, frame_done       LOAD or DRAIN active / pulse after last handshake

// rtl/rotate_engine.sv - two-entry output queue carrying {eof, sol, data}
module rotate_engine_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [1:0]   level
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (level != 2'd0);
endmodule

module rotate_engine #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        rot,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sol,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done
);
  localparam int MAX_D = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W = $clog2(MAX_D);
  localparam logic [CNT_W-1:0]  W_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  H_LAST = CNT_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_NEGW = ~A_W + A_ONE;
  localparam logic [ADDR_W-1:0] A_ROT1 = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] A_ROT2 = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_ROT3 = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t              state;
  logic [1:0]          rot_q;
  logic [CNT_W-1:0]    sx, sy, ox, oy;
  logic [ADDR_W-1:0]   waddr, raddr, row_addr;
  logic [ADDR_W-1:0]   step, row_step, start_addr;
  logic [CNT_W-1:0]    ow_last, oh_last;
  logic                rd_done, rd_vld, rd_sol, rd_eof;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   mem [IMG_W*IMG_H];
  logic [1:0]          fifo_level;
  logic [DATA_W+1:0]   fifo_rdata;
  logic                wr_en, rd_en, pop, last_rd;

  // 90/270 swap output geometry.
  assign ow_last = rot_q[0] ? H_LAST : W_LAST;
  assign oh_last = rot_q[0] ? W_LAST : H_LAST;

  // Address walk per mode: step along an output row, row_step between row
  // starts. Negative steps wrap modulo 2^ADDR_W and land back in range.
  always_comb begin
    step     = A_ONE;
    row_step = A_W;
    case (rot_q)
      2'd1:    begin step = A_NEGW; row_step = A_ONE;  end
      2'd2:    begin step = '1;     row_step = A_NEGW; end
      2'd3:    begin step = A_W;    row_step = '1;     end
      default: ;
    endcase
  end

  always_comb begin
    start_addr = '0;
    case (rot)
      2'd1:    start_addr = A_ROT1;
      2'd2:    start_addr = A_ROT2;
      2'd3:    start_addr = A_ROT3;
      default: ;
    endcase
  end

  assign wr_en   = (state == LOAD) && s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign last_rd = (ox == ow_last) && (oy == oh_last);
  // Credit check counts the slot freed by this cycle's pop so a steady
  // stream keeps one read in flight every cycle without overrunning.
  assign rd_en   = (state == DRAIN) && !rd_done &&
                   (({1'b0, fifo_level} + {2'b0, rd_vld}) < (3'd2 + {2'b0, pop}));

  // Single-port frame store: LOAD writes, DRAIN reads, never both.
  always_ff @(posedge clk) begin
    if (wr_en)      mem[waddr] <= s_data;
    else if (rd_en) rd_q       <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_sol <= 1'b0;
      rd_eof <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      rd_sol <= (ox == '0);
      rd_eof <= last_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rot_q      <= 2'd0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      ox         <= '0;
      oy         <= '0;
      waddr      <= '0;
      raddr      <= '0;
      row_addr   <= '0;
      rd_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            rot_q    <= rot;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            sx       <= '0;
            sy       <= '0;
            ox       <= '0;
            oy       <= '0;
            waddr    <= '0;
            raddr    <= start_addr;
            row_addr <= start_addr;
            rd_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            waddr <= waddr + A_ONE;
            if (sx == W_LAST) begin
              sx <= '0;
              if (sy == H_LAST) begin
                state   <= DRAIN;
                s_ready <= 1'b0;
              end else begin
                sy <= sy + 1'b1;
              end
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_en) begin
            if (ox == ow_last) begin
              ox       <= '0;
              oy       <= oy + 1'b1;
              row_addr <= row_addr + row_step;
              raddr    <= row_addr + row_step;
              if (oy == oh_last) rd_done <= 1'b1;
            end else begin
              ox    <= ox + 1'b1;
              raddr <= raddr + step;
            end
          end
          if (pop && m_eof) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rotate_engine_fifo #(.W(DATA_W + 2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld),
    .wdata ({rd_eof, rd_sol, rd_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (m_valid),
    .level (fifo_level)
  );

  assign m_data = fifo_rdata[DATA_W-1:0];
  assign m_sol  = fifo_rdata[DATA_W];
  assign m_eof  = fifo_rdata[DATA_W+1];
endmodule

// File: tb/tb_rotate_engine.sv
// tb/tb_rotate_engine.sv - scoreboard bench for rotate_engine on a 4x3 frame
module tb_rotate_engine;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int DATA_W = 8;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk, rst_n, start, s_valid, s_ready, m_valid, m_ready;
  logic [1:0]        rot;
  logic [DATA_W-1:0] s_data, m_data;
  logic              m_sol, m_eof, busy, frame_done;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int hs_count = 0;
  bit rdy_rand = 0;
  int img [NPIX];
  logic [DATA_W+1:0] sb [$];

  rotate_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rot        (rot),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sol      (m_sol),
    .m_eof      (m_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: rotate the stored 2-D image geometrically.
  task automatic push_expected(input int r);
    int ow, oh, sx, sy;
    ow = (r % 2 == 1) ? IMG_H : IMG_W;
    oh = (r % 2 == 1) ? IMG_W : IMG_H;
    for (int y = 0; y < oh; y++) begin
      for (int x = 0; x < ow; x++) begin
        case (r)
          0: begin sx = x;             sy = y;             end
          1: begin sx = y;             sy = IMG_H - 1 - x; end
          2: begin sx = IMG_W - 1 - x; sy = IMG_H - 1 - y; end
          default: begin sx = IMG_W - 1 - y; sy = x; end
        endcase
        sb.push_back({(x == ow - 1) && (y == oh - 1), x == 0, DATA_W'(img[sy * IMG_W + sx])});
      end
    end
  endtask

  task automatic do_start(input int r);
    @(posedge clk); #1;
    start = 1'b1; rot = 2'(r); s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rot = 2'($urandom_range(0, 3));
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("s_ready_in_load", s_ready, 1);
  endtask

  task automatic load(input bit rnd_valid);
    int idx = 0;
    int guard = 0;
    while (idx < NPIX && guard < 2000) begin
      @(posedge clk); #1;
      s_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = DATA_W'(img[idx]);
      rot     = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      guard++;
    end
    check("load_accepted", idx, NPIX);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    @(negedge clk);
    check("s_ready_after_load", s_ready, 0);
  endtask

  task automatic run_frame(input int r, input bit rnd_data, input bit rnd_valid);
    for (int i = 0; i < NPIX; i++) img[i] = rnd_data ? int'($urandom_range(0, 255)) : i;
    push_expected(r);
    do_start(r);
    load(rnd_valid);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("frame_idle", busy, 0);
    check("sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks stall hold
  // and the frame_done pulse shape.
  initial begin
    logic [DATA_W+1:0] held, exp_px;
    bit stall_prev = 0;
    bit done_exp = 0;
    bit done_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0; done_exp = 0; done_low = 0;
      end else begin
        if (done_low) begin
          check("frame_done_width", frame_done, 0);
          done_low = 0;
        end
        if (done_exp) begin
          check("frame_done_pulse", frame_done, 1);
          done_exp = 0;
          done_low = 1;
        end
        if (m_valid) begin
          if (stall_prev) check("stall_hold", {m_eof, m_sol, m_data}, held);
          if (m_ready) begin
            if (sb.size() == 0) begin
              chk_cnt++;
              $display("FAIL sb_extra: unexpected pixel 0x%0h", {m_eof, m_sol, m_data});
            end else begin
              exp_px = sb.pop_front();
              check("pixel", {m_eof, m_sol, m_data}, exp_px);
            end
            hs_count++;
            if (m_eof) done_exp = 1;
            stall_prev = 0;
          end else begin
            stall_prev = 1;
            held = {m_eof, m_sol, m_data};
          end
        end else begin
          stall_prev = 0;
        end
      end
    end
  end

  initial begin
    int n, g, base;
    rst_n = 1'b0; start = 1'b0; rot = 2'd0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sol", m_sol, 0);
    check("rst_m_eof", m_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;

    // rot0 at full rate: 12 consecutive output cycles
    run_frame(0, 0, 0);
    g = 0;
    while (!m_valid && g < 100) begin @(negedge clk); g++; end
    n = 1;
    while (!(m_valid && m_eof) && n < 100) begin @(negedge clk); n++; end
    check("rot0_burst_cycles", n, NPIX);
    wait_idle();

    run_frame(1, 0, 0); wait_idle();
    run_frame(3, 0, 0); wait_idle();
    run_frame(2, 0, 0); wait_idle();

    // rot1 under random backpressure and random source valid
    rdy_rand = 1;
    run_frame(1, 0, 1); wait_idle();
    rdy_rand = 0;

    // start during DRAIN and at the final handshake must be ignored
    run_frame(1, 1, 0);
    repeat (2) @(posedge clk);
    #1; start = 1'b1; rot = 2'd2;
    @(posedge clk); #1; start = 1'b0; rot = 2'd0;
    g = 0;
    while (!(m_valid && m_ready && m_eof) && g < 200) begin @(negedge clk); g++; end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("start_at_eof_busy", busy, 0);
    check("start_at_eof_s_ready", s_ready, 0);
    wait_idle();

    // reset in the middle of DRAIN
    rdy_rand = 1;
    base = hs_count;
    run_frame(1, 1, 1);
    g = 0;
    while (hs_count < base + 5 && g < 500) begin @(negedge clk); g++; end
    #3; rst_n = 1'b0;
    #1;
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(3, 1, 1); wait_idle();
    rdy_rand = 0;
    run_frame(2, 1, 0); wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
